// File: rtl/sobel_pkg.sv
// sobel_pkg: shared state encodings, error bit indices and frame-size helper for the Sobel pipeline
package sobel_pkg;
  typedef enum logic [1:0] {ST_WAIT_SOF, ST_LOAD, ST_FLUSH, ST_BUSY} state_t;
  localparam int ERR_OVF = 0;
  localparam int ERR_SOF = 1;
  localparam int ERR_SHORT = 2;
  function automatic int unsigned max_pix(input int unsigned w, input int unsigned h);
    return w * h;
  endfunction
endpackage

// File: rtl/frame_loader_bram.sv
// frame_loader_bram: stores one raster pixel frame into BRAM0 port 0 and hands it to the Sobel FSM
module frame_loader_bram
  import sobel_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int IMAGE_WIDTH = 100,
  parameter int IMAGE_HEIGHT = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_sof,
  input  logic                  i_eof,
  input  logic                  i_run_req,
  output logic                  b0_ce0,
  output logic                  b0_we0,
  output logic [ADDR_WIDTH-1:0] b0_addr0,
  output logic [DATA_WIDTH-1:0] b0_d0,
  output logic                  o_en,
  output logic [ADDR_WIDTH-1:0] o_num_cnt,
  output logic                  o_run,
  input  logic                  i_fsm_done,
  output logic                  o_busy,
  output logic [2:0]            o_err,
  input  logic                  i_err_clr
);
  localparam int unsigned MAX_PIX = max_pix(IMAGE_WIDTH, IMAGE_HEIGHT);
  localparam logic [ADDR_WIDTH-1:0] MAX_A = ADDR_WIDTH'(MAX_PIX);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(MAX_PIX - 1);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

  if (MAX_PIX == 0 || longint'(MAX_PIX) > (longint'(1) << ADDR_WIDTH) - 1) begin : g_bad_size
    $error("frame_loader_bram: IMAGE_WIDTH*IMAGE_HEIGHT does not fit ADDR_WIDTH");
  end

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d, num_q, num_d, addr_q, addr_d, wa;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic run_q, run_d, we_q, we_d, en_q, en_d, take;
  logic [2:0] err_q, err_d;

  assign o_ready = state_q == ST_WAIT_SOF || state_q == ST_LOAD;
  // a sof beat always restarts at address 0; non-sof beats only count while loading
  assign take = i_valid && o_ready && (i_sof || state_q == ST_LOAD);
  assign wa = i_sof ? '0 : cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d = take ? wa + ONE : cnt_q;
    run_d = (take && i_sof) ? i_run_req : run_q;
    num_d = num_q;
    we_d = take;
    addr_d = take ? wa : addr_q;
    data_d = take ? i_data : data_q;
    en_d = state_q == ST_FLUSH;
    err_d = i_err_clr ? '0 : err_q;
    if (take) begin
      state_d = ST_LOAD;
      if (i_sof && state_q == ST_LOAD) err_d[ERR_SOF] = 1'b1;
      if (i_eof || wa == LAST_A) begin
        state_d = ST_FLUSH;
        num_d = i_eof ? wa + ONE : MAX_A;
        if (!i_eof) err_d[ERR_OVF] = 1'b1;
        else if (wa + ONE != MAX_A) err_d[ERR_SHORT] = 1'b1;
      end
    end
    if (state_q == ST_FLUSH) state_d = ST_BUSY;
    if (state_q == ST_BUSY && i_fsm_done) state_d = ST_WAIT_SOF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_WAIT_SOF;
      cnt_q <= '0;
      num_q <= '0;
      addr_q <= '0;
      data_q <= '0;
      run_q <= 1'b0;
      we_q <= 1'b0;
      en_q <= 1'b0;
      err_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      num_q <= num_d;
      addr_q <= addr_d;
      data_q <= data_d;
      run_q <= run_d;
      we_q <= we_d;
      en_q <= en_d;
      err_q <= err_d;
    end
  end

  assign b0_ce0 = we_q;
  assign b0_we0 = we_q;
  assign b0_addr0 = addr_q;
  assign b0_d0 = data_q;
  assign o_en = en_q;
  assign o_num_cnt = num_q;
  assign o_run = run_q;
  assign o_busy = state_q == ST_FLUSH || state_q == ST_BUSY;
  assign o_err = err_q;
endmodule
